// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIBBLES = DATA_W / NIB_W;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_XOR    = 3'd2,
        OP_RED    = 3'd3,
        OP_SLL    = 3'd4,
        OP_SRA    = 3'd5,
        OP_ROR    = 3'd6,
        OP_PADDSB = 3'd7
    } opcode_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bus between the issue logic and the ALU.
interface alu_if;
    import alu_pkg::*;

    logic [DATA_W-1:0]  ALU_In1;
    logic [DATA_W-1:0]  ALU_In2;
    logic [2:0]         Opcode;
    logic [DATA_W-1:0]  ALU_Out;
    logic               Error;
    logic [FLAGS_W-1:0] Flags;

    modport master (
        output ALU_In1, ALU_In2, Opcode,
        input  ALU_Out, Error, Flags
    );

    modport slave (
        input  ALU_In1, ALU_In2, Opcode,
        output ALU_Out, Error, Flags
    );

endinterface

// File: rtl/alu_sat_add.sv
// Signed saturating adder/subtractor; clamps to the extreme of the first operand's sign on overflow.
module alu_sat_add #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sat_max;
    logic [WIDTH-1:0] sat_min;

    assign sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    assign sat_min = {1'b1, {(WIDTH-1){1'b0}}};

    // Subtraction as a + ~b + 1 so one overflow rule covers both operations
    assign b_eff = sub ? ~b : b;
    assign raw   = a + b_eff + WIDTH'(sub);
    assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    assign sum   = ovf ? (a[WIDTH-1] ? sat_min : sat_max) : raw;

endmodule

// File: rtl/alu.sv
// 16-bit execute-stage ALU: combinational result/error, registered Z/V/N flags.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    opcode_e             op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [3:0]          amt;

    logic [DATA_W-1:0]   as_sum;
    logic                as_ovf;
    logic [DATA_W-1:0]   pad_sum;
    logic [NIBBLES-1:0]  pad_ovf_unused;

    logic [8:0]          red_lo;
    logic [8:0]          red_hi;
    logic [8:0]          red_s;

    logic [DATA_W-1:0]   result_c;
    logic                error_c;
    logic [FLAGS_W-1:0]  flags;
    logic [FLAGS_W-1:0]  flags_next;

    assign op  = opcode_e'(bus.Opcode);
    assign a   = bus.ALU_In1;
    assign b   = bus.ALU_In2;
    assign amt = b[3:0];

    alu_sat_add #(.WIDTH(DATA_W)) u_addsub (
        .a   (a),
        .b   (b),
        .sub (op == OP_SUB),
        .sum (as_sum),
        .ovf (as_ovf)
    );

    // Nibble lanes are fully independent; their overflow is absorbed by saturation
    for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
        alu_sat_add #(.WIDTH(NIB_W)) u_nib (
            .a   (a[NIB_W*i +: NIB_W]),
            .b   (b[NIB_W*i +: NIB_W]),
            .sub (1'b0),
            .sum (pad_sum[NIB_W*i +: NIB_W]),
            .ovf (pad_ovf_unused[i])
        );
    end

    // Byte-sum reduction: only bit 8 of the total sets the sign extension
    assign red_lo = {1'b0, a[7:0]}  + {1'b0, b[7:0]};
    assign red_hi = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign red_s  = 9'(red_lo + red_hi);

    always_comb begin
        result_c = '0;
        error_c  = 1'b0;
        case (op)
            OP_ADD,
            OP_SUB:    begin
                result_c = as_sum;
                error_c  = as_ovf;
            end
            OP_XOR:    result_c = a ^ b;
            OP_RED:    result_c = {{8{red_s[8]}}, red_s[7:0]};
            OP_SLL:    result_c = a << amt;
            OP_SRA:    result_c = DATA_W'($signed(a) >>> amt);
            OP_ROR:    result_c = (a >> amt) | (a << (5'd16 - {1'b0, amt}));
            OP_PADDSB: result_c = pad_sum;
            default:   result_c = '0;
        endcase
    end

    // Next-flag selection: arithmetic updates all, logic/shift updates Z only
    always_comb begin
        flags_next = flags;
        case (op)
            OP_ADD,
            OP_SUB: begin
                flags_next[FLAG_Z] = (result_c == '0);
                flags_next[FLAG_V] = error_c;
                flags_next[FLAG_N] = result_c[DATA_W-1];
            end
            OP_XOR,
            OP_SLL,
            OP_SRA,
            OP_ROR: flags_next[FLAG_Z] = (result_c == '0);
            default: flags_next = flags;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= flags_next;
        end
    end

    assign bus.ALU_Out = result_c;
    assign bus.Error   = error_c;
    assign bus.Flags   = flags;

endmodule

// File: tb/tb_alu.sv
// Directed table plus random checks of the ALU against an arithmetic reference model.
module tb_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [2:0] mflags;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        err;
        logic [2:0]  flags;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Behavioural model computed from the arithmetic definitions of each operation
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] out, output logic err);
        int sa, sb, r, amt, lo, hi, s, na, nb, ns;
        logic [15:0] t;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = int'(b[3:0]);
        err = 1'b0;
        out = '0;
        case (op)
            3'd0: begin r = sa + sb; err = (sat16(r) != r); r = sat16(r); out = r[15:0]; end
            3'd1: begin r = sa - sb; err = (sat16(r) != r); r = sat16(r); out = r[15:0]; end
            3'd2: out = a ^ b;
            3'd3: begin
                lo = int'(a[7:0]) + int'(b[7:0]);
                hi = int'(a[15:8]) + int'(b[15:8]);
                s  = lo + hi;
                out = {(s[8] ? 8'hFF : 8'h00), s[7:0]};
            end
            3'd4: begin r = int'(a) * (1 << amt); out = r[15:0]; end
            3'd5: begin r = sa >>> amt; out = r[15:0]; end
            3'd6: begin
                t = a;
                for (int k = 0; k < amt; k++) t = {t[0], t[15:1]};
                out = t;
            end
            default: begin
                for (int k = 0; k < 4; k++) begin
                    na = int'(a[4*k +: 4]); if (na > 7) na -= 16;
                    nb = int'(b[4*k +: 4]); if (nb > 7) nb -= 16;
                    ns = na + nb;
                    if (ns > 7)  ns = 7;
                    if (ns < -8) ns = -8;
                    out[4*k +: 4] = 4'(ns);
                end
            end
        endcase
    endfunction

    function automatic logic [2:0] next_flags(input logic [2:0] op, input logic [15:0] out,
                                              input logic err, input logic [2:0] cur);
        logic [2:0] f;
        f = cur;
        if (op == 3'd0 || op == 3'd1) f = {out == 16'h0, err, out[15]};
        else if (op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6) f[2] = (out == 16'h0);
        return f;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.Opcode  = op;
        bus.ALU_In1 = a;
        bus.ALU_In2 = b;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] e_out;
    logic        e_err;
    logic [2:0]  op_r;
    logic [15:0] a_r, b_r;

    initial begin
        tbl[0]  = '{3'd0, 16'h7000, 16'h7000, 16'h7FFF, 1'b1, 3'b010};
        tbl[1]  = '{3'd0, 16'h8000, 16'h8001, 16'h8000, 1'b1, 3'b011};
        tbl[2]  = '{3'd0, 16'h0003, 16'hFFFD, 16'h0000, 1'b0, 3'b100};
        tbl[3]  = '{3'd1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 3'b011};
        tbl[4]  = '{3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 3'b001};
        tbl[5]  = '{3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFC, 1'b0, 3'b001};
        tbl[6]  = '{3'd3, 16'h0102, 16'h0304, 16'h000A, 1'b0, 3'b001};
        tbl[7]  = '{3'd4, 16'h8001, 16'h0001, 16'h0002, 1'b0, 3'b001};
        tbl[8]  = '{3'd5, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 3'b001};
        tbl[9]  = '{3'd6, 16'h0001, 16'h0004, 16'h1000, 1'b0, 3'b001};
        tbl[10] = '{3'd6, 16'h1234, 16'h0010, 16'h1234, 1'b0, 3'b001};
        tbl[11] = '{3'd4, 16'h1234, 16'hFFF0, 16'h1234, 1'b0, 3'b001};
        tbl[12] = '{3'd5, 16'h9234, 16'h0000, 16'h9234, 1'b0, 3'b001};
        tbl[13] = '{3'd2, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 3'b101};
        tbl[14] = '{3'd7, 16'h7788, 16'h1188, 16'h7788, 1'b0, 3'b101};
        tbl[15] = '{3'd7, 16'h1234, 16'h1111, 16'h2345, 1'b0, 3'b101};
        tbl[16] = '{3'd1, 16'h0000, 16'h8000, 16'h7FFF, 1'b1, 3'b010};
        tbl[17] = '{3'd2, 16'h00FF, 16'hFF00, 16'hFFFF, 1'b0, 3'b010};
        tbl[18] = '{3'd0, 16'h8000, 16'h8000, 16'h8000, 1'b1, 3'b011};

        drive(3'd2, 16'h0, 16'h0);
        step();
        step();
        check("reset_flags", 16'(bus.Flags), 16'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_out", i), bus.ALU_Out, tbl[i].out);
            check($sformatf("tbl%0d_err", i), 16'(bus.Error), 16'(tbl[i].err));
            step();
            check($sformatf("tbl%0d_flags", i), 16'(bus.Flags), 16'(tbl[i].flags));
        end

        // Reset wins over a saturating ADD; result path is unaffected
        drive(3'd0, 16'h7000, 16'h7000);
        rst = 1'b1;
        step();
        check("rst_flags", 16'(bus.Flags), 16'h0);
        check("rst_out", bus.ALU_Out, 16'h7FFF);
        check("rst_err", 16'(bus.Error), 16'h1);
        rst = 1'b0;
        step();
        check("post_rst_flags", 16'(bus.Flags), 16'h2);

        mflags = 3'b010;
        for (int i = 0; i < 400; i++) begin
            op_r = 3'($urandom_range(0, 7));
            a_r  = 16'($urandom);
            b_r  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a_r = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 7) == 0) b_r = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 9) == 0) b_r = a_r;
            rst = ($urandom_range(0, 19) == 0);
            drive(op_r, a_r, b_r);
            model(op_r, a_r, b_r, e_out, e_err);
            check("rnd_out", bus.ALU_Out, e_out);
            check("rnd_err", 16'(bus.Error), 16'(e_err));
            mflags = rst ? 3'b000 : next_flags(op_r, e_out, e_err, mflags);
            step();
            check("rnd_flags", 16'(bus.Flags), 16'(mflags));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
